// File: rtl/image_xfer_pkg.sv
// ---------------------------------------------------------------------------
// image_xfer_pkg
// Shared constants, state encoding and address helper for the image transfer
// scheduler that moves 640x360 4-bit images between a frame buffer and an SD
// card, one 512-byte sector at a time.
// No ports (package).
// ---------------------------------------------------------------------------
package image_xfer_pkg;

  localparam int unsigned SECTOR_SIZE       = 512;
  localparam int unsigned SECTORS_PER_IMAGE = 450;
  localparam int unsigned MAX_IMAGES        = 64;
  localparam int unsigned IMAGE_SIZE        = SECTOR_SIZE * SECTORS_PER_IMAGE;
  localparam int unsigned WDOG_CYCLES       = 1 << 20;
  localparam int unsigned BUF_AW            = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_ISSUE,
    ST_XFER,
    ST_NEXT_SECTOR,
    ST_FINISH
  } xfer_state_t;

  // Byte address of a sector on the card: images are laid out back to back.
  function automatic logic [31:0] sd_byte_addr(
    input logic [5:0]  slot,
    input logic [8:0]  sector,
    input int unsigned sectors_per_image,
    input int unsigned sector_size
  );
    logic [31:0] lin;
    lin = 32'(slot) * sectors_per_image + 32'(sector);
    return lin * sector_size;
  endfunction

endpackage

// File: rtl/image_transfer_scheduler_if.sv
// ---------------------------------------------------------------------------
// image_transfer_scheduler_if
// Groups the request/status handshake, the SD controller byte interface and
// the frame-buffer port of the scheduler.
//   master : scheduler side (drives status, SD commands, buffer writes)
//   slave  : environment side (requests, SD controller, buffer read data)
// ---------------------------------------------------------------------------
interface image_transfer_scheduler_if;
  import image_xfer_pkg::*;

  // request / status
  logic              load_req_in;
  logic [5:0]        load_idx_in;
  logic              save_req_in;
  logic              busy_out;
  logic              done_out;
  logic              err_out;
  logic [6:0]        image_count_out;
  // SD controller
  logic              sd_ready_in;
  logic              sd_rd_out;
  logic              sd_wr_out;
  logic [31:0]       sd_addr_out;
  logic [7:0]        sd_dout_in;
  logic              sd_byte_available_in;
  logic [7:0]        sd_din_out;
  logic              sd_ready_for_next_byte_in;
  // frame buffer
  logic [BUF_AW-1:0] buf_addr_out;
  logic [3:0]        buf_din_out;
  logic              buf_we_out;
  logic [3:0]        buf_dout_in;

  modport master (
    input  load_req_in, load_idx_in, save_req_in,
    output busy_out, done_out, err_out, image_count_out,
    input  sd_ready_in, sd_dout_in, sd_byte_available_in, sd_ready_for_next_byte_in,
    output sd_rd_out, sd_wr_out, sd_addr_out, sd_din_out,
    output buf_addr_out, buf_din_out, buf_we_out,
    input  buf_dout_in
  );

  modport slave (
    output load_req_in, load_idx_in, save_req_in,
    input  busy_out, done_out, err_out, image_count_out,
    output sd_ready_in, sd_dout_in, sd_byte_available_in, sd_ready_for_next_byte_in,
    input  sd_rd_out, sd_wr_out, sd_addr_out, sd_din_out,
    input  buf_addr_out, buf_din_out, buf_we_out,
    output buf_dout_in
  );
endinterface

// File: rtl/image_transfer_scheduler_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Registered rising-edge detector: one registered copy of the input; the
// strobe is high only in the first cycle the input is seen high.
//   clk_in   : clock
//   rst_n_in : synchronous active-low reset
//   sig_in   : level input
//   rise_out : rising-edge strobe (combinational from sig_in and the copy)
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic sig_in,
  output logic rise_out
);

  logic r_prev;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) r_prev <= 1'b0;
    else           r_prev <= sig_in;
  end

  assign rise_out = sig_in & ~r_prev;

endmodule

// File: rtl/image_transfer_scheduler.sv
// ---------------------------------------------------------------------------
// image_transfer_scheduler
// Moves one image between the 4-bit frame buffer and the SD card, sector by
// sector. Load: SD bytes -> buffer (low nibble). Save: buffer -> SD bytes
// (zero-extended nibble), written to the next free image slot.
//   clk_in   : clock, all logic on posedge
//   rst_n_in : synchronous active-low reset
//   bus      : request/status, SD byte interface and buffer port (master)
// Parameters default to the real card geometry; they exist so the geometry
// and stall limit can be shrunk for short simulations.
// ---------------------------------------------------------------------------
module image_transfer_scheduler
  import image_xfer_pkg::*;
#(
  parameter int unsigned P_SECTOR_SIZE = SECTOR_SIZE,
  parameter int unsigned P_SECTORS     = SECTORS_PER_IMAGE,
  parameter int unsigned P_WDOG        = WDOG_CYCLES
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  image_transfer_scheduler_if.master  bus
);

  localparam int BCW = $clog2(P_SECTOR_SIZE);
  localparam int WDW = $clog2(P_WDOG + 1);
  localparam logic [BCW-1:0] LAST_BYTE   = BCW'(P_SECTOR_SIZE - 1);
  localparam logic [8:0]     LAST_SECTOR = 9'(P_SECTORS - 1);
  localparam logic [WDW-1:0] WDOG_LAST   = WDW'(P_WDOG - 1);

  xfer_state_t       r_state, w_state_next;
  logic              r_is_save, w_is_save_next;
  logic [5:0]        r_slot, w_slot_next;
  logic [8:0]        r_sector, w_sector_next;
  logic [BCW-1:0]    r_byte_cnt, w_byte_cnt_next;
  logic [BUF_AW-1:0] r_index, w_index_next;
  logic [6:0]        r_image_count, w_image_count_next;
  logic [WDW-1:0]    r_wdog, w_wdog_next;
  logic              r_done, w_done_next;
  logic              r_err, w_err_next;
  logic              r_sd_rd, w_sd_rd_next;
  logic              r_sd_wr, w_sd_wr_next;
  logic [31:0]       r_sd_addr, w_sd_addr_next;
  logic [7:0]        r_sd_din, w_sd_din_next;
  logic              r_buf_we, w_buf_we_next;
  logic [3:0]        r_buf_din, w_buf_din_next;
  logic [BUF_AW-1:0] r_buf_addr, w_buf_addr_next;

  logic w_rise_avail, w_rise_rfn, w_event, w_step, w_wdog_hit;
  logic w_unused;

  edge_detect u_avail_edge (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .sig_in   (bus.sd_byte_available_in),
    .rise_out (w_rise_avail)
  );

  edge_detect u_rfn_edge (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .sig_in   (bus.sd_ready_for_next_byte_in),
    .rise_out (w_rise_rfn)
  );

  // Only the strobe that matches the transfer direction counts, and only in XFER.
  assign w_event = (r_state == ST_XFER) && (r_is_save ? w_rise_rfn : w_rise_avail);
  // A save advances on the byte event itself; a load advances one cycle later,
  // in the cycle the buffer write happens, so the last write of a sector still
  // lands inside XFER.
  assign w_step = r_is_save ? w_event : r_buf_we;
  assign w_wdog_hit = (r_wdog == WDOG_LAST) &&
                      ((r_state == ST_WAIT_READY) || (r_state == ST_ISSUE) || (r_state == ST_XFER));
  assign w_unused = ^bus.sd_dout_in[7:4];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state       <= ST_IDLE;
      r_is_save     <= 1'b0;
      r_slot        <= '0;
      r_sector      <= '0;
      r_byte_cnt    <= '0;
      r_index       <= '0;
      r_image_count <= '0;
      r_wdog        <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_sd_rd       <= 1'b0;
      r_sd_wr       <= 1'b0;
      r_sd_addr     <= '0;
      r_sd_din      <= '0;
      r_buf_we      <= 1'b0;
      r_buf_din     <= '0;
      r_buf_addr    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_is_save     <= w_is_save_next;
      r_slot        <= w_slot_next;
      r_sector      <= w_sector_next;
      r_byte_cnt    <= w_byte_cnt_next;
      r_index       <= w_index_next;
      r_image_count <= w_image_count_next;
      r_wdog        <= w_wdog_next;
      r_done        <= w_done_next;
      r_err         <= w_err_next;
      r_sd_rd       <= w_sd_rd_next;
      r_sd_wr       <= w_sd_wr_next;
      r_sd_addr     <= w_sd_addr_next;
      r_sd_din      <= w_sd_din_next;
      r_buf_we      <= w_buf_we_next;
      r_buf_din     <= w_buf_din_next;
      r_buf_addr    <= w_buf_addr_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_is_save_next     = r_is_save;
    w_slot_next        = r_slot;
    w_sector_next      = r_sector;
    w_byte_cnt_next    = r_byte_cnt;
    w_index_next       = r_index;
    w_image_count_next = r_image_count;
    w_wdog_next        = '0;
    w_done_next        = 1'b0;
    w_err_next         = 1'b0;
    w_sd_rd_next       = r_sd_rd;
    w_sd_wr_next       = r_sd_wr;
    w_sd_addr_next     = r_sd_addr;
    w_sd_din_next      = r_sd_din;
    w_buf_we_next      = 1'b0;
    w_buf_din_next     = r_buf_din;
    w_buf_addr_next    = r_buf_addr;

    case (r_state)
      ST_IDLE: begin
        // Save has priority; a simultaneous load is dropped.
        if (bus.save_req_in) begin
          if (r_image_count == 7'(MAX_IMAGES)) begin
            w_done_next = 1'b1;
            w_err_next  = 1'b1;
          end else begin
            w_state_next    = ST_WAIT_READY;
            w_is_save_next  = 1'b1;
            w_slot_next     = r_image_count[5:0];
            w_sector_next   = '0;
            w_byte_cnt_next = '0;
            w_index_next    = '0;
          end
        end else if (bus.load_req_in) begin
          if ({1'b0, bus.load_idx_in} >= r_image_count) begin
            w_done_next = 1'b1;
            w_err_next  = 1'b1;
          end else begin
            w_state_next    = ST_WAIT_READY;
            w_is_save_next  = 1'b0;
            w_slot_next     = bus.load_idx_in;
            w_sector_next   = '0;
            w_byte_cnt_next = '0;
            w_index_next    = '0;
          end
        end
      end

      ST_WAIT_READY: begin
        if (bus.sd_ready_in) begin
          w_state_next   = ST_ISSUE;
          w_sd_addr_next = sd_byte_addr(r_slot, r_sector, P_SECTORS, P_SECTOR_SIZE);
          w_sd_rd_next   = ~r_is_save;
          w_sd_wr_next   = r_is_save;
        end
      end

      // The command is held until the controller drops ready to show it took it.
      ST_ISSUE: begin
        if (!bus.sd_ready_in) begin
          w_state_next = ST_XFER;
          w_sd_rd_next = 1'b0;
          w_sd_wr_next = 1'b0;
        end
      end

      ST_XFER: begin
        if (w_event && !r_is_save) begin
          w_buf_we_next   = 1'b1;
          w_buf_addr_next = r_index;
          w_buf_din_next  = bus.sd_dout_in[3:0];
        end
        if (w_event && r_is_save) begin
          w_sd_din_next = {4'b0, bus.buf_dout_in};
        end
        if (w_step) begin
          w_index_next = r_index + BUF_AW'(1);
          if (r_byte_cnt == LAST_BYTE) begin
            w_byte_cnt_next = '0;
            w_state_next    = ST_NEXT_SECTOR;
          end else begin
            w_byte_cnt_next = r_byte_cnt + BCW'(1);
          end
        end
      end

      ST_NEXT_SECTOR: begin
        w_sector_next = r_sector + 9'd1;
        if (r_sector == LAST_SECTOR) begin
          w_state_next = ST_FINISH;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = ST_WAIT_READY;
        end
      end

      ST_FINISH: begin
        if (r_is_save) w_image_count_next = r_image_count + 7'd1;
        w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase

    // Stall abort; a byte event in the same cycle restarts the count instead.
    if (w_wdog_hit && !w_event) begin
      w_state_next  = ST_IDLE;
      w_sd_rd_next  = 1'b0;
      w_sd_wr_next  = 1'b0;
      w_done_next   = 1'b1;
      w_err_next    = 1'b1;
      w_buf_we_next = 1'b0;
    end

    // During a save the buffer read address follows the byte index directly,
    // giving the 2-cycle read plenty of time before the next byte event.
    if (w_is_save_next && (w_state_next != ST_IDLE)) w_buf_addr_next = w_index_next;

    if ((w_state_next != r_state) || w_event || (r_state == ST_IDLE)) w_wdog_next = '0;
    else                                                               w_wdog_next = r_wdog + WDW'(1);
  end

  assign bus.busy_out        = (r_state != ST_IDLE);
  assign bus.done_out        = r_done;
  assign bus.err_out         = r_err;
  assign bus.image_count_out = r_image_count;
  assign bus.sd_rd_out       = r_sd_rd;
  assign bus.sd_wr_out       = r_sd_wr;
  assign bus.sd_addr_out     = r_sd_addr;
  assign bus.sd_din_out      = r_sd_din;
  assign bus.buf_addr_out    = r_buf_addr;
  assign bus.buf_din_out     = r_buf_din;
  assign bus.buf_we_out      = r_buf_we;

endmodule

// File: tb/tb_image_transfer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_image_transfer_scheduler
// Directed bench on a shrunk card geometry (8-byte sectors, 4 sectors per
// image, 200-cycle stall limit) with a scripted SD controller and a 2-cycle
// latency buffer model.
// ---------------------------------------------------------------------------
module tb_image_transfer_scheduler;
  import image_xfer_pkg::*;

  localparam int SSZ  = 8;
  localparam int NSEC = 4;
  localparam int WDOG = 200;
  localparam int IMG  = SSZ * NSEC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b0;
  always #5 clk = ~clk;

  image_transfer_scheduler_if bus();

  image_transfer_scheduler #(
    .P_SECTOR_SIZE (SSZ),
    .P_SECTORS     (NSEC),
    .P_WDOG        (WDOG)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  // Buffer model: 2-cycle registered read; preload fills a save pattern.
  logic [3:0] mem [0:63];
  logic [3:0] rd_pipe;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 4'((i * 7 + 3) % 16);
    end else if (bus.buf_we_out) begin
      mem[bus.buf_addr_out[5:0]] <= bus.buf_din_out;
    end
    rd_pipe         <= mem[bus.buf_addr_out[5:0]];
    bus.buf_dout_in <= rd_pipe;
  end

  // Free-running event counters; tests work with deltas.
  int n_done = 0, n_err = 0, n_rd = 0, n_wr = 0, n_we = 0, n_both = 0;
  always @(negedge clk) begin
    if (bus.done_out === 1'b1) n_done <= n_done + 1;
    if (bus.err_out === 1'b1) n_err <= n_err + 1;
    if (bus.sd_rd_out === 1'b1) n_rd <= n_rd + 1;
    if (bus.sd_wr_out === 1'b1) n_wr <= n_wr + 1;
    if (bus.buf_we_out === 1'b1) n_we <= n_we + 1;
    if ((bus.sd_rd_out === 1'b1) && (bus.sd_wr_out === 1'b1)) n_both <= n_both + 1;
  end

  task automatic request(input logic save, input logic load, input logic [5:0] idx);
    bus.save_req_in = save;
    bus.load_req_in = load;
    bus.load_idx_in = idx;
    @(negedge clk);
    bus.save_req_in = 1'b0;
    bus.load_req_in = 1'b0;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  // Scripted SD controller. stop_bytes < 0: stop before the command of
  // stop_sec (ready stays low); otherwise stop after stop_bytes bytes of it.
  task automatic serve(input logic do_save, input int slot, input int stop_sec, input int stop_bytes);
    int waited;
    int k;
    for (int s = 0; s < NSEC; s++) begin
      if (s == stop_sec && stop_bytes < 0) return;
      bus.sd_ready_in = 1'b1;
      waited = 0;
      while (!(bus.sd_rd_out || bus.sd_wr_out) && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (waited >= 50) begin
        errors++;
        $display("FAIL cmd_timeout sector %0d: no sd_rd/sd_wr seen, required within 50 cycles", s);
        bus.sd_ready_in = 1'b0;
        return;
      end
      checks++;
      if (bus.sd_addr_out !== 32'((slot * NSEC + s) * SSZ)) begin
        errors++;
        $display("FAIL sd_addr slot %0d sector %0d: got %0d expected %0d", slot, s,
                 bus.sd_addr_out, (slot * NSEC + s) * SSZ);
      end
      checks++;
      if ((bus.sd_wr_out !== do_save) || (bus.sd_rd_out !== !do_save)) begin
        errors++;
        $display("FAIL cmd_dir sector %0d: got rd=%b wr=%b expected save=%b", s,
                 bus.sd_rd_out, bus.sd_wr_out, do_save);
      end
      bus.sd_ready_in = 1'b0;
      repeat (2) @(negedge clk);
      for (int b = 0; b < SSZ; b++) begin
        if (s == stop_sec && b == stop_bytes) return;
        k = s * SSZ + b;
        if (do_save) begin
          bus.sd_ready_for_next_byte_in = 1'b1;
        end else begin
          bus.sd_dout_in = {4'hA, 4'(k % 16)};
          bus.sd_byte_available_in = 1'b1;
        end
        @(negedge clk);
        bus.sd_ready_for_next_byte_in = 1'b0;
        bus.sd_byte_available_in = 1'b0;
        if (do_save) begin
          checks++;
          if (bus.sd_din_out !== {4'h0, 4'((k * 7 + 3) % 16)}) begin
            errors++;
            $display("FAIL sd_din byte %0d: got %h expected %h", k, bus.sd_din_out,
                     {4'h0, 4'((k * 7 + 3) % 16)});
          end
        end
        repeat (3) @(negedge clk);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({bus.busy_out, bus.done_out, bus.err_out, bus.image_count_out, bus.sd_rd_out,
         bus.sd_wr_out, bus.sd_addr_out, bus.sd_din_out, bus.buf_addr_out,
         bus.buf_din_out, bus.buf_we_out} !== '0) begin
      errors++;
      $display("FAIL %s: outputs busy=%b done=%b err=%b cnt=%0d rd=%b wr=%b addr=%h din=%h baddr=%h bdin=%h we=%b, required all 0",
               tag, bus.busy_out, bus.done_out, bus.err_out, bus.image_count_out, bus.sd_rd_out,
               bus.sd_wr_out, bus.sd_addr_out, bus.sd_din_out, bus.buf_addr_out,
               bus.buf_din_out, bus.buf_we_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_save();
    int d0, e0, we0, rd0;
    do_preload();
    d0 = n_done; e0 = n_err; we0 = n_we; rd0 = n_rd;
    request(1'b1, 1'b0, 6'd0);
    checks++;
    if (bus.busy_out !== 1'b1) begin
      errors++;
      $display("FAIL save_busy: got %b expected 1", bus.busy_out);
    end
    serve(1'b1, 0, -1, 0);
    repeat (6) @(negedge clk);
    checks++;
    if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      errors++;
      $display("FAIL save_done: done pulses %0d err pulses %0d, expected 1 and 0", n_done - d0, n_err - e0);
    end
    checks++;
    if (bus.image_count_out !== 7'd1) begin
      errors++;
      $display("FAIL save_count: got %0d expected 1", bus.image_count_out);
    end
    checks++;
    if ((n_we - we0) !== 0 || (n_rd - rd0) !== 0) begin
      errors++;
      $display("FAIL save_no_write: buf writes %0d sd_rd cycles %0d, expected 0 and 0", n_we - we0, n_rd - rd0);
    end
    checks++;
    if (bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL save_idle: busy got %b expected 0", bus.busy_out);
    end
    $display("test_save: slot 0 saved, count=%0d", bus.image_count_out);
  endtask

  task automatic test_load();
    int d0, e0, we0, wr0, bad;
    d0 = n_done; e0 = n_err; we0 = n_we; wr0 = n_wr;
    request(1'b0, 1'b1, 6'd0);
    serve(1'b0, 0, -1, 0);
    repeat (6) @(negedge clk);
    bad = 0;
    for (int k = 0; k < IMG; k++) begin
      checks++;
      if (mem[k] !== 4'(k % 16)) begin
        errors++;
        bad++;
        $display("FAIL load_data index %0d: got %h expected %h", k, mem[k], 4'(k % 16));
      end
    end
    checks++;
    if ((n_we - we0) !== IMG) begin
      errors++;
      $display("FAIL load_writes: got %0d expected %0d", n_we - we0, IMG);
    end
    checks++;
    if ((n_done - d0) !== 1 || (n_err - e0) !== 0 || (n_wr - wr0) !== 0) begin
      errors++;
      $display("FAIL load_done: done %0d err %0d wr %0d, expected 1 0 0", n_done - d0, n_err - e0, n_wr - wr0);
    end
    $display("test_load: idx 0 loaded, %0d bad nibbles", bad);
  endtask

  task automatic test_load_reject();
    logic [5:0] idx_tab [2];
    int rd0;
    idx_tab[0] = 6'd3;
    idx_tab[1] = 6'd1;  // equal to the image count: just out of range
    rd0 = n_rd;
    for (int t = 0; t < 2; t++) begin
      request(1'b0, 1'b1, idx_tab[t]);
      checks++;
      if ({bus.done_out, bus.err_out, bus.busy_out} !== 3'b110) begin
        errors++;
        $display("FAIL reject_pulse idx %0d: done/err/busy got %b%b%b expected 110", idx_tab[t],
                 bus.done_out, bus.err_out, bus.busy_out);
      end
      @(negedge clk);
      checks++;
      if ({bus.done_out, bus.err_out} !== 2'b00) begin
        errors++;
        $display("FAIL reject_single idx %0d: done/err got %b%b expected 00", idx_tab[t], bus.done_out, bus.err_out);
      end
      $display("test_load_reject: idx %0d rejected", idx_tab[t]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ((n_rd - rd0) !== 0 || bus.image_count_out !== 7'd1) begin
      errors++;
      $display("FAIL reject_quiet: sd_rd cycles %0d count %0d, expected 0 and 1", n_rd - rd0, bus.image_count_out);
    end
  endtask

  task automatic test_same_cycle();
    int rd0, wr0;
    do_preload();
    rd0 = n_rd; wr0 = n_wr;
    request(1'b1, 1'b1, 6'd0);
    serve(1'b1, 1, -1, 0);
    repeat (6) @(negedge clk);
    checks++;
    if ((n_rd - rd0) !== 0 || (n_wr - wr0) < NSEC) begin
      errors++;
      $display("FAIL same_cycle_dir: sd_rd cycles %0d sd_wr cycles %0d, expected 0 and >=%0d", n_rd - rd0, n_wr - wr0, NSEC);
    end
    checks++;
    if (bus.image_count_out !== 7'd2) begin
      errors++;
      $display("FAIL same_cycle_count: got %0d expected 2", bus.image_count_out);
    end
    $display("test_same_cycle: save won, count=%0d", bus.image_count_out);
  endtask

  task automatic test_watchdog();
    int c;
    request(1'b1, 1'b0, 6'd0);
    serve(1'b1, 2, 2, -1);
    // From here: NEXT_SECTOR then WAIT_READY for WDOG cycles, so the error
    // pulse shows up about WDOG-2 negedges later.
    c = 0;
    while (bus.err_out !== 1'b1 && c < WDOG + 50) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c < WDOG - 4 || c > WDOG + 2) begin
      errors++;
      $display("FAIL wdog_time: err after %0d cycles, required %0d..%0d", c, WDOG - 4, WDOG + 2);
    end
    checks++;
    if (bus.done_out !== 1'b1 || bus.sd_wr_out !== 1'b0) begin
      errors++;
      $display("FAIL wdog_pulse: done got %b wr got %b, expected 1 and 0", bus.done_out, bus.sd_wr_out);
    end
    @(negedge clk);
    checks++;
    if (bus.busy_out !== 1'b0 || bus.image_count_out !== 7'd2) begin
      errors++;
      $display("FAIL wdog_idle: busy %b count %0d, expected 0 and 2", bus.busy_out, bus.image_count_out);
    end
    $display("test_watchdog: stall aborted after %0d cycles", c);
  endtask

  task automatic test_reset_mid_save();
    int d0;
    d0 = n_done;
    request(1'b1, 1'b0, 6'd0);
    serve(1'b1, 2, 2, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid_save");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ((n_done - d0) !== 0 || bus.image_count_out !== 7'd0) begin
      errors++;
      $display("FAIL reset_abort: done pulses %0d count %0d, expected 0 and 0", n_done - d0, bus.image_count_out);
    end
    $display("test_reset_mid_save: aborted in sector 2");
  endtask

  task automatic test_capacity();
    int d0, wr0;
    do_preload();
    d0 = n_done;
    for (int i = 0; i < 64; i++) begin
      request(1'b1, 1'b0, 6'd0);
      serve(1'b1, i, -1, 0);
      repeat (4) @(negedge clk);
    end
    checks++;
    if (bus.image_count_out !== 7'd64 || (n_done - d0) !== 64) begin
      errors++;
      $display("FAIL capacity_fill: count %0d done pulses %0d, expected 64 and 64", bus.image_count_out, n_done - d0);
    end
    wr0 = n_wr;
    request(1'b1, 1'b0, 6'd0);
    checks++;
    if ({bus.done_out, bus.err_out, bus.busy_out} !== 3'b110) begin
      errors++;
      $display("FAIL capacity_reject: done/err/busy got %b%b%b expected 110", bus.done_out, bus.err_out, bus.busy_out);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.image_count_out !== 7'd64 || (n_wr - wr0) !== 0) begin
      errors++;
      $display("FAIL capacity_quiet: count %0d wr cycles %0d, expected 64 and 0", bus.image_count_out, n_wr - wr0);
    end
    $display("test_capacity: 64 images saved, 65th rejected");
  endtask

  initial begin
    bus.load_req_in = 1'b0;
    bus.load_idx_in = '0;
    bus.save_req_in = 1'b0;
    bus.sd_ready_in = 1'b0;
    bus.sd_dout_in = '0;
    bus.sd_byte_available_in = 1'b0;
    bus.sd_ready_for_next_byte_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_save();
    test_load();
    test_load_reject();
    test_same_cycle();
    test_watchdog();
    test_reset_mid_save();
    test_capacity();
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL rd_wr_exclusive: both high for %0d cycles, expected 0", n_both);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_transfer_scheduler.md
IMAGE_TRANSFER_SCHEDULER -- requirements
Module: image_transfer_scheduler

Interface
REQ-001 SECTOR_SIZE, 512, bytes per SD sector; SECTORS_PER_IMAGE, 450, sectors per 640x360 4-bit image; MAX_IMAGES, 64, image slots on card; WDOG_CYCLES, 2^20, stall limit.
REQ-002 clk_in  in  1  single clock (25 MHz SD domain); all logic on posedge.
REQ-003 rst_n_in  in  1  reset, synchronous, active-low.
REQ-004 load_req_in  in  1  request to load image load_idx_in into buffer; load_idx_in  in  6  image slot.
REQ-005 save_req_in  in  1  request to save buffer as next image slot.
REQ-006 busy_out  out  1  transfer in progress; done_out  out  1  one-cycle completion pulse; err_out  out  1  one-cycle pulse, coincident with done_out, on rejected or aborted request.
REQ-007 image_count_out  out  7  number of images saved since reset.
REQ-008 sd_ready_in  in  1; sd_rd_out  out  1; sd_wr_out  out  1; sd_addr_out  out  32  byte address; sd_dout_in  in  8; sd_byte_available_in  in  1; sd_din_out  out  8; sd_ready_for_next_byte_in  in  1.
REQ-009 buf_addr_out  out  18  buffer index; buf_din_out  out  4; buf_we_out  out  1; buf_dout_in  in  4  (2-cycle read latency).

Function
REQ-010 States: IDLE, WAIT_READY, ISSUE, XFER, NEXT_SECTOR, FINISH.
REQ-011 Requests sampled only in IDLE; requests while busy_out=1 are ignored, not queued.
REQ-012 save_req_in and load_req_in in the same IDLE cycle: save wins, load dropped.
REQ-013 Load with load_idx_in >= image_count_out, or save with image_count_out == MAX_IMAGES: next cycle done_out=err_out=1, no SD or buffer activity, return to IDLE.
REQ-014 Accepted request: busy_out=1 from next cycle until the FINISH cycle inclusive; byte index and sector counter cleared to 0.
REQ-015 sd_addr_out = (slot*SECTORS_PER_IMAGE + sector)*SECTOR_SIZE, 32-bit unsigned, slot = load_idx_in (latched) or image_count_out for save; stable from ISSUE through end of XFER.
REQ-016 WAIT_READY -> ISSUE when sd_ready_in=1; ISSUE holds sd_rd_out (load) or sd_wr_out (save) at 1 until sd_ready_in observed 0, then deasserts and enters XFER.
REQ-017 Byte event = rising edge of sd_byte_available_in (load) or sd_ready_for_next_byte_in (save), detected via one registered copy; level-high does not retrigger.
REQ-018 Load byte event: next cycle buf_we_out=1 for exactly one cycle, buf_addr_out=current index, buf_din_out=sd_dout_in[3:0]; index increments the following cycle.
REQ-019 Save: buf_addr_out = current index continuously; on byte event sd_din_out <= {4'b0, buf_dout_in}, index then increments; byte events are guaranteed >=4 cycles apart.
REQ-020 512th byte event of a sector -> NEXT_SECTOR: sector+1; if sector+1 == SECTORS_PER_IMAGE -> FINISH else WAIT_READY.
REQ-021 FINISH: done_out=1 one cycle; save increments image_count_out; -> IDLE.
REQ-022 Watchdog: counter cleared on every state change and byte event; reaching WDOG_CYCLES in WAIT_READY/ISSUE/XFER -> deassert sd_rd_out/sd_wr_out, done_out=err_out=1, image_count_out unchanged, -> IDLE.
REQ-023 buf_we_out never 1 outside a load XFER; sd_rd_out and sd_wr_out never both 1.

Reset
REQ-024 rst_n_in=0 at posedge: state IDLE; all outputs 0 (sd_addr_out, buf_addr_out, sd_din_out included); image_count_out, counters, edge registers 0.
REQ-025 Reset mid-transfer aborts immediately with no done_out pulse; partial saves are not counted.

Structure
REQ-026 SECTOR_SIZE, SECTORS_PER_IMAGE, MAX_IMAGES, IMAGE_SIZE and the state enum live in shared package image_xfer_pkg.
REQ-027 One sub-module: edge_detect (registered rising-edge detector), instantiated for both byte-event strobes.

Verification
REQ-028 Save from reset with SD model: 230400 buffer reads, sd_addr_out 0..(449*512) step 512, done_out once, image_count_out=1.
REQ-029 Load idx 0 after save, model returns byte k = k mod 16: buffer holds k mod 16 at index k, 230400 writes, err_out=0.
REQ-030 Load idx 3 with image_count_out=1 -> done_out=err_out=1 next cycle, sd_rd_out never asserted.
REQ-031 save_req_in and load_req_in same cycle -> sd_wr_out asserted, sd_rd_out stays 0.
REQ-032 sd_ready_in held 0 in sector 5 -> err_out after 2^20 cycles, IDLE, image_count_out unchanged.
REQ-033 rst_n_in=0 during sector 100 of a save -> all outputs 0 next cycle, image_count_out=0, no done_out.
